// File: rtl/kt8_pkg.sv
// ---------------------------------------------------------------------------
// kt8_pkg
// Shared definitions for the KT8 RAM subsystem: RAM geometry, the arbiter
// state encoding and the requester index constants.
// ---------------------------------------------------------------------------
package kt8_pkg;

    localparam int KT8_ADDR_W = 4;
    localparam int KT8_DATA_W = 8;

    // Arbiter sequencing states; ACCESS drives the RAM, CAPTURE samples it.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } arb_state_t;

    // Requester indices, as reported on gnt_o.
    localparam logic REQ_CPU  = 1'b0;
    localparam logic REQ_LOAD = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// ---------------------------------------------------------------------------
// arb_rr2
// Two-way round-robin picker. The winner is combinational from the (already
// masked) requests and the pointer; the pointer only moves when both
// requests compete and a grant is actually taken.
//
// Ports:
//   clk_i   system clock, rising edge
//   rst_i   synchronous reset, active-high (pointer favours REQ_CPU)
//   req     masked requests, bit N = requester N
//   take    a grant is being taken this cycle (arbiter is idle)
//   winner  index of the selected requester
//   valid   at least one request is present
// ---------------------------------------------------------------------------
module arb_rr2
    import kt8_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req,
    input  logic       take,
    output logic       winner,
    output logic       valid
);

    logic ptr;
    logic ptr_next;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        winner   = REQ_CPU;
        ptr_next = ptr;
        unique case (req)
            2'b01:   winner = REQ_CPU;
            2'b10:   winner = REQ_LOAD;
            2'b11: begin
                // Contention: serve the pointer, then favour the other side.
                winner   = ptr;
                ptr_next = ~ptr;
            end
            default: winner = REQ_CPU;
        endcase
    end

    assign valid = |req;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr <= REQ_CPU;
        end else if (take && valid) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Shares the KT8 16x8 single-port RAM between requester 0 (CPU datapath) and
// requester 1 (loader/debug). Each access is a fixed three-cycle sequence
// ACCESS -> CAPTURE -> IDLE(ack), so requesters never see RAM timing.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   reqN_i/weN_i/addrN_i/wdataN_i  requester N access request and payload
//   ackN_o                       one-cycle completion pulse for requester N
//   rdataN_o                     data returned to N, held until its next ack
//   ram_addr_o/ram_data_o/ram_we_o  registered RAM control
//   ram_rdata_i                  RAM read data
//   busy_o                       transaction in progress
//   gnt_o                        requester owning the current/last access
// ---------------------------------------------------------------------------
module ram_arbiter
    import kt8_pkg::*;
#(
    parameter int ADDR_W = KT8_ADDR_W,
    parameter int DATA_W = KT8_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              req0_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    output logic              ack0_o,
    output logic [DATA_W-1:0] rdata0_o,

    input  logic              req1_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              ack1_o,
    output logic [DATA_W-1:0] rdata1_o,

    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    output logic              ram_we_o,
    input  logic [DATA_W-1:0] ram_rdata_i,

    output logic              busy_o,
    output logic              gnt_o
);

    arb_state_t state;

    logic [1:0]        req_masked;
    logic              winner;
    logic              any_req;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // A requester being acked this cycle still holds its old request; mask
    // it so the same access is never granted twice.
    assign req_masked = {req1_i & ~ack1_o, req0_i & ~ack0_o};

    arb_rr2 u_arb (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .req    (req_masked),
        .take   (state == IDLE),
        .winner (winner),
        .valid  (any_req)
    );

    always_comb begin
        sel_we    = we0_i;
        sel_addr  = addr0_i;
        sel_wdata = wdata0_i;
        if (winner == REQ_LOAD) begin
            sel_we    = we1_i;
            sel_addr  = addr1_i;
            sel_wdata = wdata1_i;
        end
    end

    assign busy_o = (state != IDLE);

    // The RAM control registers double as the payload latch: loaded at the
    // grant edge and held through ACCESS and CAPTURE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: only control and output registers are reset; the RAM array
            // itself lives outside and keeps its contents across reset.
            state      <= IDLE;
            gnt_o      <= REQ_CPU;
            ack0_o     <= 1'b0;
            ack1_o     <= 1'b0;
            rdata0_o   <= '0;
            rdata1_o   <= '0;
            ram_addr_o <= '0;
            ram_data_o <= '0;
            ram_we_o   <= 1'b0;
        end else begin
            ack0_o <= 1'b0;
            ack1_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_o      <= winner;
                        ram_addr_o <= sel_addr;
                        ram_data_o <= sel_wdata;
                        ram_we_o   <= sel_we;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    // The write commits at this edge; address stays put.
                    ram_we_o <= 1'b0;
                    state    <= CAPTURE;
                end
                CAPTURE: begin
                    if (gnt_o == REQ_LOAD) begin
                        rdata1_o <= ram_rdata_i;
                        ack1_o   <= 1'b1;
                    end else begin
                        rdata0_o <= ram_rdata_i;
                        ack0_o   <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    ram_we_o <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
// Directed bench for ram_arbiter with a behavioural 16x8 RAM (write at the
// rising edge when we is high, combinational read).
// ---------------------------------------------------------------------------
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, we0, req1, we1;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1;
    logic [7:0] rdata0, rdata1;
    logic [3:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_we;
    logic [7:0] ram_rdata;
    logic       busy, gnt;

    int n_checks = 0;
    int n_errors = 0;
    int we_count = 0;

    logic [7:0] mem [16] = '{0: 8'hC3, 2: 8'h3C, default: 8'h00};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_data;
            we_count      <= we_count + 1;
        end
    end
    assign ram_rdata = mem[ram_addr];

    ram_arbiter dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req0_i      (req0),
        .we0_i       (we0),
        .addr0_i     (addr0),
        .wdata0_i    (wdata0),
        .ack0_o      (ack0),
        .rdata0_o    (rdata0),
        .req1_i      (req1),
        .we1_i       (we1),
        .addr1_i     (addr1),
        .wdata1_i    (wdata1),
        .ack1_o      (ack1),
        .rdata1_o    (rdata1),
        .ram_addr_o  (ram_addr),
        .ram_data_o  (ram_data),
        .ram_we_o    (ram_we),
        .ram_rdata_i (ram_rdata),
        .busy_o      (busy),
        .gnt_o       (gnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until ackN is seen; returns 0 if the bound expires.
    task automatic wait_ack(input int idx, input int limit, output int n);
        bit found;
        found = 1'b0;
        n     = 0;
        for (int i = 1; i <= limit && !found; i++) begin
            tick();
            if ((idx == 0 && ack0) || (idx == 1 && ack1)) begin
                n     = i;
                found = 1'b1;
            end
        end
    endtask

    initial begin
        int n, t0, t1, g_first, g_second, base, k, ack1_seen, ack0_seen;
        int times [3];
        logic [1:0] exp_ack;

        rst = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd0; wdata0 = 8'h00;
        req1 = 1'b0; we1 = 1'b0; addr1 = 4'd0; wdata1 = 8'h00;

        // Reset held two cycles with req0 high.
        tick();
        check("rst_ack0", ack0, 0);
        check("rst_ack1", ack1, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_busy", busy, 0);
        check("rst_gnt", gnt, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_data", ram_data, 0);
        check("rst_rdata0", rdata0, 0);
        check("rst_rdata1", rdata1, 0);
        tick();
        check("rst2_busy", busy, 0);
        check("rst2_ram_we", ram_we, 0);
        rst = 1'b0;
        wait_ack(0, 10, n);
        check("rst_first_ack_latency", n, 3);
        check("rst_first_rdata0", rdata0, 8'hC3);
        check("rst_no_write", we_count, 0);
        req0 = 1'b0;
        tick();

        // Write 0x0A to address 1, stepping through each state.
        base = we_count;
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd1; wdata0 = 8'h0A;
        tick();
        check("wr_access_busy", busy, 1);
        check("wr_access_we", ram_we, 1);
        check("wr_access_addr", ram_addr, 4'd1);
        check("wr_access_data", ram_data, 8'h0A);
        check("wr_access_gnt", gnt, 0);
        tick();
        check("wr_capture_we", ram_we, 0);
        check("wr_capture_busy", busy, 1);
        check("wr_capture_ack", ack0, 0);
        tick();
        check("wr_ack", ack0, 1);
        check("wr_ack_busy", busy, 0);
        check("wr_rdata_echo", rdata0, 8'h0A);
        req0 = 1'b0;
        tick();
        check("wr_ack_pulse_width", ack0, 0);

        // Read back address 1; wdata is ignored for reads.
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd1; wdata0 = 8'hEE;
        wait_ack(0, 10, n);
        check("rd_latency", n, 3);
        check("rd_rdata0", rdata0, 8'h0A);
        req0 = 1'b0;
        check("wr_rd_we_cycles", we_count - base, 1);
        tick();

        // Simultaneous: req0 reads addr 2, req1 writes 0x55 to addr 3.
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd2;
        req1 = 1'b1; we1 = 1'b1; addr1 = 4'd3; wdata1 = 8'h55;
        t0 = 0; t1 = 0; g_first = -1; g_second = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 1) g_first = int'(gnt);
            if (i == 4) g_second = int'(gnt);
            if (ack0 && t0 == 0) begin t0 = i; req0 = 1'b0; end
            if (ack1 && t1 == 0) begin t1 = i; req1 = 1'b0; end
        end
        check("sim_ack0_time", t0, 3);
        check("sim_ack1_time", t1, 6);
        check("sim_gnt_first", g_first, 0);
        check("sim_gnt_second", g_second, 1);
        check("sim_rdata0", rdata0, 8'h3C);
        check("sim_rdata1", rdata1, 8'h55);

        // Fairness after a reset: both held, acks alternate 0,1,0,1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd3;
        for (int i = 1; i <= 13; i++) begin
            tick();
            exp_ack = 2'b00;
            if (i == 3 || i == 9)  exp_ack = 2'b01;
            if (i == 6 || i == 12) exp_ack = 2'b10;
            check($sformatf("fair_cycle%0d", i), {ack1, ack0}, exp_ack);
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) tick();
        check("fair_rdata0", rdata0, 8'h0A);
        check("fair_rdata1", rdata1, 8'h55);
        check("fair_idle", busy, 0);

        // Stale request: a lone held req0 gets one access per 4 cycles.
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd2;
        k = 0; ack1_seen = 0;
        times = '{0, 0, 0};
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (ack0 && k < 3) begin times[k] = i; k++; end
            if (ack1) ack1_seen++;
        end
        req0 = 1'b0;
        check("stale_ack_a", times[0], 3);
        check("stale_ack_b", times[1], 7);
        check("stale_ack_c", times[2], 11);
        check("stale_no_ack1", ack1_seen, 0);
        repeat (2) tick();

        // Reset during ACCESS of a write of 0xFF to address 5.
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd5; wdata0 = 8'hFF;
        tick();
        check("rstw_access_we", ram_we, 1);
        rst = 1'b1;
        tick();
        check("rstw_busy", busy, 0);
        check("rstw_ack0", ack0, 0);
        check("rstw_ram_we", ram_we, 0);
        rst = 1'b0; req0 = 1'b0;
        ack0_seen = 0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (ack0) ack0_seen++;
            if (i == 1) check("rstw_busy_after", busy, 0);
        end
        check("rstw_no_ack", ack0_seen, 0);
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd5;
        wait_ack(1, 10, n);
        check("rstw_read_latency", n, 3);
        check("rstw_read_data", rdata1, 8'hFF);
        req1 = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule
